// File: rtl/cam_capture_ctrl_if.sv
// Bundled host control, camera bus and frame-buffer write port of the capture controller.
interface cam_capture_ctrl_if #(
  parameter int ADDR_W = 17,
  parameter int LINE_W = 12,
  parameter int ROW_W  = 10
);
  logic              start, abort, ack;
  logic [LINE_W-1:0] cfg_bytes_per_line;
  logic [ROW_W-1:0]  cfg_lines;
  logic              vsync, href;
  logic [7:0]        din;
  logic [15:0]       pix_data;
  logic              pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic              busy, done, err_line, err_frame;
  logic [19:0]       byte_total;

  modport master (
    output start, abort, ack, cfg_bytes_per_line, cfg_lines, vsync, href, din,
    input  pix_data, pix_valid, pix_addr, busy, done, err_line, err_frame, byte_total
  );
  modport slave (
    input  start, abort, ack, cfg_bytes_per_line, cfg_lines, vsync, href, din,
    output pix_data, pix_valid, pix_addr, busy, done, err_line, err_frame, byte_total
  );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Camera frame-capture sequencer: arms on start, syncs to a frame boundary, packs
// byte pairs into 16-bit pixels and checks line/frame geometry.
module cam_capture_ctrl #(
  parameter int ADDR_W = 17,
  parameter int LINE_W = 12,
  parameter int ROW_W  = 10
) (
  input logic               pclk,
  input logic               reset,
  cam_capture_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_VS_HI, WAIT_VS_LO, CAPTURE, DONE_S} state_t;
  state_t state, state_nxt;

  logic              vs_q, hr_q, phase;
  logic [7:0]        hold;
  logic [LINE_W-1:0] line_bytes;
  logic [ROW_W-1:0]  line_cnt, line_cnt_inc;
  logic [19:0]       frame_bytes, byte_total;
  logic [15:0]       pix_data;
  logic              pix_valid, err_line, err_frame;
  logic [ADDR_W-1:0] pix_addr;
  logic              vs_rise, vs_fall, arm, in_cap, take, line_close, line_bad;

  assign vs_rise      = bus.vsync & ~vs_q;
  assign vs_fall      = ~bus.vsync & vs_q;
  assign arm          = (state == IDLE) & bus.start & ~bus.abort;
  assign in_cap       = (state == CAPTURE) & ~bus.abort;
  // A line closes on href falling, or when the frame ends with href still high.
  assign line_close   = in_cap & ((hr_q & ~bus.href) | (vs_rise & bus.href));
  assign line_bad     = (line_bytes != bus.cfg_bytes_per_line) | phase | (vs_rise & bus.href);
  assign take         = in_cap & bus.href & ~vs_rise;
  assign line_cnt_inc = (&line_cnt) ? line_cnt : line_cnt + 1'b1;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:       if (bus.start) state_nxt = WAIT_VS_HI;
        WAIT_VS_HI: if (bus.vsync) state_nxt = WAIT_VS_LO;
        WAIT_VS_LO: if (vs_fall)   state_nxt = CAPTURE;
        CAPTURE:    if (vs_rise)   state_nxt = DONE_S;
        DONE_S:     if (bus.ack)   state_nxt = IDLE;
        default:                   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vs_q        <= 1'b0;
      hr_q        <= 1'b0;
      phase       <= 1'b0;
      hold        <= '0;
      line_bytes  <= '0;
      line_cnt    <= '0;
      frame_bytes <= '0;
      byte_total  <= 20'hFFFFF;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      pix_addr    <= '0;
      err_line    <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      vs_q      <= bus.vsync;
      hr_q      <= bus.href;
      pix_valid <= 1'b0;
      if (pix_valid) pix_addr <= pix_addr + 1'b1;
      if (arm) begin
        phase       <= 1'b0;
        line_bytes  <= '0;
        line_cnt    <= '0;
        frame_bytes <= '0;
        pix_addr    <= '0;
        err_line    <= 1'b0;
        err_frame   <= 1'b0;
      end
      if (take) begin
        frame_bytes <= (&frame_bytes) ? frame_bytes : frame_bytes + 1'b1;
        line_bytes  <= (&line_bytes) ? line_bytes : line_bytes + 1'b1;
        phase       <= ~phase;
        if (!phase) hold <= bus.din;
        else if (line_cnt < bus.cfg_lines) begin
          // Lines past the configured count are measured but not written.
          pix_data  <= {hold, bus.din};
          pix_valid <= 1'b1;
        end
      end
      if (line_close) begin
        if (line_bad) err_line <= 1'b1;
        line_cnt   <= line_cnt_inc;
        line_bytes <= '0;
        phase      <= 1'b0;
      end
      if (in_cap & vs_rise) begin
        if ((line_close ? line_cnt_inc : line_cnt) != bus.cfg_lines) err_frame <= 1'b1;
        byte_total <= frame_bytes;
      end
    end
  end

  assign bus.pix_data   = pix_data;
  assign bus.pix_valid  = pix_valid;
  assign bus.pix_addr   = pix_addr;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE_S);
  assign bus.err_line   = err_line;
  assign bus.err_frame  = err_frame;
  assign bus.byte_total = byte_total;
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench: directed frames plus random frames against a queue-based capture model.
module tb_cam_capture_ctrl;
  logic pclk, reset;
  int checks = 0, failures = 0;

  cam_capture_ctrl_if bus ();
  cam_capture_ctrl dut (.pclk(pclk), .reset(reset), .bus(bus));

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 wait vsync high, 2 wait vsync fall, 3 capture, 4 done
  int          mode, lines, fbytes, emitted;
  logic [7:0]  lq[$];
  bit          vs_p, hr_p, m_line, m_frame, exp_valid;
  logic [15:0] exp_data;
  logic [16:0] exp_addr;
  logic [19:0] m_total;

  function automatic void close_line(input bit forced);
    if (forced || lq.size() != int'(bus.cfg_bytes_per_line) || (lq.size() % 2) != 0) m_line = 1;
    if (lines < 1023) lines++;
    lq.delete();
  endfunction

  always @(posedge pclk or posedge reset) begin
    if (reset) begin
      mode = 0; lines = 0; fbytes = 0; emitted = 0; lq.delete();
      vs_p = 0; hr_p = 0; m_line = 0; m_frame = 0; exp_valid = 0;
      m_total = 20'hFFFFF;
    end else begin
      exp_valid = 0;
      if (bus.abort) mode = 0;
      else begin
        case (mode)
          0: if (bus.start) begin
               mode = 1; m_line = 0; m_frame = 0; lines = 0; fbytes = 0; emitted = 0; lq.delete();
             end
          1: if (bus.vsync) mode = 2;
          2: if (vs_p && !bus.vsync) mode = 3;
          3: begin
               if (bus.vsync && !vs_p) begin
                 if (bus.href || hr_p) close_line(bus.href);
                 if (lines != int'(bus.cfg_lines)) m_frame = 1;
                 m_total = 20'(fbytes);
                 mode = 4;
               end else if (hr_p && !bus.href) close_line(0);
               else if (bus.href) begin
                 lq.push_back(bus.din);
                 if (fbytes < 20'hFFFFF) fbytes++;
                 if (lq.size() % 2 == 0 && lines < int'(bus.cfg_lines)) begin
                   exp_valid = 1;
                   exp_data  = {lq[lq.size()-2], lq[lq.size()-1]};
                   exp_addr  = 17'(emitted);
                   emitted++;
                 end
               end
             end
          4: if (bus.ack) mode = 0;
          default: mode = 0;
        endcase
      end
      vs_p = bus.vsync;
      hr_p = bus.href;
    end
  end

  int pix_seen, first_addr, last_addr;
  bit done_seen;
  always @(negedge pclk) begin
    if (!reset) begin
      check("pix_valid", 32'(bus.pix_valid), 32'(exp_valid));
      if (exp_valid && bus.pix_valid) begin
        check("pix_data", 32'(bus.pix_data), 32'(exp_data));
        check("pix_addr", 32'(bus.pix_addr), 32'(exp_addr));
      end
      check("busy", 32'(bus.busy), 32'(mode != 0));
      check("done", 32'(bus.done), 32'(mode == 4));
      check("err_line", 32'(bus.err_line), 32'(m_line));
      check("err_frame", 32'(bus.err_frame), 32'(m_frame));
      check("byte_total", 32'(bus.byte_total), 32'(m_total));
      if (bus.pix_valid) begin
        if (pix_seen == 0) first_addr = int'(bus.pix_addr);
        last_addr = int'(bus.pix_addr);
        pix_seen++;
      end
      if (bus.done) done_seen = 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic send_line(input int n);
    for (int b = 0; b < n; b++) begin
      bus.href = 1'b1; bus.din = 8'($urandom); tick();
    end
    bus.href = 1'b0; tick(2);
  endtask

  int lens[8];
  task automatic run_frame(input int n, input int abort_after);
    bus.vsync = 1'b1; tick(2); bus.vsync = 1'b0; tick(2);
    for (int i = 0; i < n; i++) begin
      send_line(lens[i]);
      if (i == abort_after) begin bus.abort = 1'b1; tick(); bus.abort = 1'b0; tick(); return; end
    end
    bus.vsync = 1'b1; tick(2); bus.vsync = 1'b0; tick();
  endtask

  task automatic arm();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic clear_stats();
    pix_seen = 0; first_addr = -1; last_addr = -1; done_seen = 0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1; tick(); bus.ack = 1'b0; tick();
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
    check({tag, "_pix_addr"}, 32'(bus.pix_addr), 0);
    check({tag, "_pix_data"}, 32'(bus.pix_data), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_errs"}, {30'd0, bus.err_line, bus.err_frame}, 0);
    check({tag, "_byte_total"}, 32'(bus.byte_total), 32'hFFFFF);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.abort = 0; bus.ack = 0; bus.vsync = 0; bus.href = 0; bus.din = 0;
    bus.cfg_bytes_per_line = 12'd8; bus.cfg_lines = 10'd3;
    clear_stats();
    tick(3);
    reset_outputs("reset");
    reset = 1'b0; tick();

    // Nominal 8x3 frame
    clear_stats(); lens = '{8, 8, 8, 0, 0, 0, 0, 0};
    arm(); run_frame(3, -1);
    check("t1_pixels", pix_seen, 12);
    check("t1_first_addr", first_addr, 0);
    check("t1_last_addr", last_addr, 11);
    check("t1_byte_total", 32'(bus.byte_total), 24);
    check("t1_done", 32'(bus.done), 1);
    check("t1_errs", {30'd0, bus.err_line, bus.err_frame}, 0);
    do_ack();
    check("t1_busy_after_ack", 32'(bus.busy), 0);

    // Armed mid-frame: href bursts before the first vsync must be ignored
    clear_stats(); lens = '{8, 8, 8, 0, 0, 0, 0, 0};
    arm(); send_line(8); send_line(8);
    check("t2_no_early_pix", pix_seen, 0);
    run_frame(3, -1);
    check("t2_pixels", pix_seen, 12);
    check("t2_first_addr", first_addr, 0);
    do_ack();

    // Short second line
    clear_stats(); lens = '{8, 7, 8, 0, 0, 0, 0, 0};
    arm(); run_frame(3, -1);
    check("t3_pixels", pix_seen, 11);
    check("t3_byte_total", 32'(bus.byte_total), 23);
    check("t3_err_line", 32'(bus.err_line), 1);
    check("t3_err_frame", 32'(bus.err_frame), 0);
    do_ack();

    // Extra line beyond cfg_lines
    clear_stats(); lens = '{8, 8, 8, 8, 0, 0, 0, 0};
    arm(); run_frame(4, -1);
    check("t4_pixels", pix_seen, 12);
    check("t4_byte_total", 32'(bus.byte_total), 32);
    check("t4_err_frame", 32'(bus.err_frame), 1);
    check("t4_err_line", 32'(bus.err_line), 0);
    do_ack();

    // Abort after 5 pixels, from reset
    reset = 1'b1; tick(); reset = 1'b0; tick();
    clear_stats(); lens = '{8, 2, 8, 0, 0, 0, 0, 0};
    arm(); run_frame(3, 1);
    check("t5_pixels", pix_seen, 5);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_byte_total", 32'(bus.byte_total), 32'hFFFFF);
    tick(4);
    check("t5_done_never", 32'(done_seen), 0);

    // start and ack together in DONE: ack wins, nothing armed
    clear_stats(); lens = '{8, 8, 8, 0, 0, 0, 0, 0};
    arm(); run_frame(3, -1);
    check("t6_done", 32'(bus.done), 1);
    bus.start = 1'b1; bus.ack = 1'b1; tick(); bus.start = 1'b0; bus.ack = 1'b0;
    check("t6_busy", 32'(bus.busy), 0);
    clear_stats();
    bus.vsync = 1'b1; tick(2); bus.vsync = 1'b0; tick(2); send_line(8);
    check("t6_no_capture", pix_seen, 0);
    check("t6_still_idle", 32'(bus.busy), 0);

    // Asynchronous reset in the middle of a line
    lens = '{8, 8, 8, 0, 0, 0, 0, 0};
    arm(); bus.vsync = 1'b1; tick(2); bus.vsync = 1'b0; tick(2);
    for (int b = 0; b < 5; b++) begin bus.href = 1'b1; bus.din = 8'($urandom); tick(); end
    #2 reset = 1'b1;
    #1 reset_outputs("async");
    bus.href = 1'b0;
    tick(); reset = 1'b0; tick();
    clear_stats(); tick(4);
    check("async_no_pix", pix_seen, 0);

    // Random frames against the model
    for (int f = 0; f < 40; f++) begin
      int n, ab;
      bus.cfg_bytes_per_line = 12'(2 * $urandom_range(1, 5));
      bus.cfg_lines = 10'($urandom_range(1, 4));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        lens[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : int'(bus.cfg_bytes_per_line);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      arm();
      run_frame(n, ab);
      tick($urandom_range(0, 3));
      bus.start = 1'($urandom_range(0, 1)); bus.ack = 1'b1; tick();
      bus.start = 1'b0; bus.ack = 1'b0; tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Frame-capture sequencer between the camera parallel bus (pclk/href/vsync/data) and the frame-buffer write port.
- Arms on a start request, waits for a clean frame boundary, then packs byte pairs into 16-bit pixels with sequential write addresses.
- Checks line length and line count against configured dimensions; reports the total byte count and done/error status to the host, which acknowledges.

Parameters:
ADDR_W, 17, pixel address width (320x240 = 76800 pixels fits)
LINE_W, 12, width of per-line byte counter and cfg_bytes_per_line
ROW_W, 10, width of line counter and cfg_lines

Ports:
pclk  in  1  camera pixel clock; the only clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle arm request, honoured only in IDLE
abort  in  1  return to IDLE immediately; highest priority
ack  in  1  host acknowledge of done, honoured only in DONE
cfg_bytes_per_line  in  LINE_W  expected bytes per line (even, nonzero)
cfg_lines  in  ROW_W  expected lines per frame (nonzero)
vsync  in  1  frame sync, high = vertical blanking pulse
href  in  1  line valid, high = data byte on din
din  in  8  camera data byte
pix_data  out  16  packed pixel {first byte, second byte}
pix_valid  out  1  one-cycle write strobe for pix_data/pix_addr
pix_addr  out  ADDR_W  pixel index within frame
busy  out  1  high in any state except IDLE
done  out  1  high in DONE
err_line  out  1  sticky: any line length != cfg_bytes_per_line, or odd byte count
err_frame  out  1  sticky: line count != cfg_lines
byte_total  out  20  bytes captured in last completed frame

Behaviour:
- Reset (asynchronous): state=IDLE; pix_data=0, pix_valid=0, pix_addr=0, busy=0, done=0, err_line=0, err_frame=0; byte_total=20'hFFFFF (no measurement yet).
- All inputs are sampled at the rising edge of pclk. Edge detection uses a one-cycle registered copy of vsync and href.
- States:
  - IDLE: start -> WAIT_VS_HI. Errors, counters and pix_addr are cleared on entry to WAIT_VS_HI; byte_total is kept.
  - WAIT_VS_HI: wait for sampled vsync=1 -> WAIT_VS_LO. Prevents capture from starting mid-frame.
  - WAIT_VS_LO: vsync falling edge (prev=1, now=0) -> CAPTURE.
  - CAPTURE: each edge with href=1 samples din.
    - Even-position byte is held.
    - Odd-position byte forms pix_data={held, din}. pix_valid is registered, so it is high in the cycle after the second byte's edge.
    - pix_addr increments by 1 after each pix_valid and wraps modulo 2^ADDR_W.
  - CAPTURE, href falling edge: line ends.
    - Line byte count != cfg_bytes_per_line sets err_line.
    - A dangling odd byte is discarded and sets err_line.
    - Line counter increments (saturates at 2^ROW_W-1) and the line byte counter clears.
  - CAPTURE, lines beyond cfg_lines: bytes are counted, but pix_valid is suppressed.
  - CAPTURE, vsync rising edge: frame ends -> DONE.
    - If href is still 1 on that edge, the partial line is closed as a line and err_line is set.
    - err_frame is set if line count != cfg_lines.
    - byte_total is loaded with the frame byte counter.
  - DONE: done=1 until ack -> IDLE.
- Frame byte counter: 20 bits, saturates at 20'hFFFFF, never wraps.
- Line byte counter: saturates at 2^LINE_W-1.
- start outside IDLE is ignored.
- start and ack in the same cycle in DONE: ack wins -> IDLE, and start is dropped.
- abort in any state: -> IDLE next edge.
  - pix_valid is forced to 0 that cycle.
  - byte_total and error flags are unchanged.
  - done is not asserted.
- reset mid-frame: all state returns to reset values asynchronously. No further pix_valid until a new start.
- Latency from the second byte of the last pixel to pix_valid: 1 cycle. From vsync rising to done=1: 1 cycle.

Test Plan:
- Config 8 bytes x 3 lines. Start, vsync pulse, then 3 lines of 8 bytes, then vsync high -> 12 pix_valid, pix_addr 0..11, byte_total=24, done=1, err_line=0, err_frame=0; ack -> IDLE, busy=0.
- Start asserted while vsync low mid-frame, with href bursts present -> no pix_valid until vsync goes high then low; first captured pixel has pix_addr=0.
- Second line has 7 bytes -> err_line=1. The odd byte is dropped, giving 11 pixels total, and byte_total=23.
- 4 lines sent with cfg_lines=3 -> exactly 12 pix_valid, err_frame=1, byte_total=32.
- abort asserted after 5 pixels -> IDLE next cycle, done never 1, byte_total holds its previous value (20'hFFFFF after reset).
- In DONE, start and ack in the same cycle -> IDLE, busy=0, and no capture is armed. Async reset mid-line -> all outputs return to reset values without waiting for a pclk edge.
